// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the multicycle MIPS control path.
package mips_pkg;

  localparam int unsigned STATE_W = 4;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUControl encodings
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // alu_op selector into the ALU decoder; NONE yields an all-zero ALUControl
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PCSrc encodings
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps alu_op/funct to ALUControl; funct_legal_o flags a supported R-type funct
// independently of alu_op so DECODE can vet the instruction early.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_legal_o
);

  logic [2:0] funct_ctl;

  // funct lookup and alu_op selection
  always_comb begin
    funct_legal_o = 1'b1;
    funct_ctl     = ALUC_AND;
    case (funct_i)
      FN_ADD:  funct_ctl = ALUC_ADD;
      FN_SUB:  funct_ctl = ALUC_SUB;
      FN_AND:  funct_ctl = ALUC_AND;
      FN_OR:   funct_ctl = ALUC_OR;
      FN_SLT:  funct_ctl = ALUC_SLT;
      default: funct_legal_o = 1'b0;
    endcase

    case (alu_op_i)
      ALUOP_ADD:   alu_control_o = ALUC_ADD;
      ALUOP_SUB:   alu_control_o = ALUC_SUB;
      ALUOP_FUNCT: alu_control_o = funct_ctl;
      default:     alu_control_o = 3'b000;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait handshake and sticky illegal flag.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  // Datapath width is documentation only; control logic is width-independent.
  localparam int unsigned width_unused = WIDTH;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [1:0] alu_op;
  logic       funct_legal;
  logic       mem_req_c, mem_write_c, ir_write_c, reg_write_c, pc_en_c;

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct_i       (funct),
    .alu_control_o (ALUControl),
    .funct_legal_o (funct_legal)
  );

  // State and sticky illegal flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    pc_en_c     = 1'b0;
    IorD        = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    PCSrc       = PC_ALU;
    alu_op      = ALUOP_NONE;

    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        ir_write_c = mem_ready;
        pc_en_c    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        alu_op  = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_legal) begin
              state_d = S_EXECUTE;
            end else begin
              illegal_d = 1'b1;
              state_d   = S_FETCH;
            end
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_ADD;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        IorD      = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg    = 1'b1;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        IorD        = 1'b1;
        mem_write_c = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst      = 1'b1;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = PC_ALUOUT;
        pc_en_c = zero;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_ADD;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = PC_JUMP;
        pc_en_c = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are killed asynchronously while reset is held
  assign mem_req   = mem_req_c & rst;
  assign MemWrite  = mem_write_c & rst;
  assign IRWrite   = ir_write_c & rst;
  assign RegWrite  = reg_write_c & rst;
  assign PCEn      = pc_en_c & rst;
  assign illegal   = illegal_q;
  assign state_dbg = 4'(state_q);

endmodule
